imem_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the `RISC_V` core. It accepts a framed byte stream, assembles little-endian 32-bit words, and writes them into the instruction memory through a dedicated write port. It holds the core in reset until a complete, checksum-verified image has been written. On a length or checksum failure it never releases the core.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/word_assembler.sv | 49 ++++
 rtl/imem_loader.sv | 120 ++++++++++++
 tb/tb_imem_loader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module : imem_loader_pkg
// Brief  : Shared state encoding and frame constants for the boot loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN_LO = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_DATA   = 3'd2,
        ST_CSUM   = 3'd3,
        ST_RUN    = 3'd4,
        ST_ERROR  = 3'd5
    } loader_state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

`default_nettype wire

// File: rtl/word_assembler.sv
// ============================================================================
// Module : word_assembler
// Brief  : 8->32 little-endian packer; one-cycle word_valid with registered word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0] idx;
    logic [23:0]      partial;

    assign last_byte = (idx == IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx        <= '0;
            partial    <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (byte_valid) begin
                // Shift in from the top so the first byte ends up in bits [7:0].
                partial <= {byte_data, partial[23:8]};
                idx     <= idx + 1'b1;
                if (last_byte) begin
                    word       <= {byte_data, partial};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module : imem_loader
// Brief  : Framed byte-stream boot loader; holds the core until a verified load.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error
);

    localparam int          LEN_W    = LEN_BYTES * 8;
    localparam logic [31:0] CAPACITY = 32'(1) << ADDR_WIDTH;

    loader_state_t    state;
    logic [7:0]       csum_acc;
    logic [LEN_W-1:0] len_word;
    logic [LEN_W-1:0] word_cnt;
    logic [LEN_W-1:0] len_next;
    logic             accept;
    logic             last_byte;

    assign accept   = in_valid && in_ready;
    assign len_next = {in_data, len_word[7:0]};

    word_assembler u_word_assembler (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (accept && (state == ST_DATA)),
        .byte_data  (in_data),
        .last_byte  (last_byte),
        .word_valid (imem_we),
        .word       (imem_wdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_LEN_LO;
            csum_acc  <= '0;
            len_word  <= '0;
            word_cnt  <= '0;
            in_ready  <= 1'b0;
            imem_addr <= '0;
            core_hold <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (accept && (state != ST_CSUM))
                csum_acc <= csum_acc ^ in_data;

            case (state)
                ST_LEN_LO: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        len_word[7:0] <= in_data;
                        state         <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        len_word <= len_next;
                        word_cnt <= '0;
                        if (32'(len_next) > CAPACITY) begin
                            state    <= ST_ERROR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else if (len_next == '0) begin
                            state <= ST_CSUM;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept && last_byte) begin
                        // Address is latched with the word so both appear alongside imem_we.
                        imem_addr <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(word_cnt);
                        word_cnt  <= word_cnt + 1'b1;
                        if (word_cnt == len_word - 1'b1)
                            state <= ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == csum_acc) begin
                            state     <= ST_RUN;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module : tb_imem_loader
// Brief  : Self-checking bench: directed table, hand sequences, random frames.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready, imem_we, core_hold, done, error;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .error      (error)
    );

    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    logic [7:0]    frame[$];
    bit            exp_done, exp_err;
    int            exp_len;

    always @(negedge clk) begin
        if (rst && imem_we) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    // Reference: interpret the frame directly from the framing rules.
    task automatic model();
        int        n;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        n = int'(frame[0]) + 256 * int'(frame[1]);
        if (n > (1 << AW)) begin
            exp_err  = 1'b1;
            exp_done = 1'b0;
            exp_len  = 2;
            return;
        end
        x = frame[0] ^ frame[1];
        for (int w = 0; w < n; w++) begin
            exp_addr.push_back(AW'(w % (1 << AW)));
            exp_data.push_back({frame[2+4*w+3], frame[2+4*w+2], frame[2+4*w+1], frame[2+4*w]});
            for (int k = 0; k < 4; k++) x ^= frame[2+4*w+k];
        end
        exp_len  = 3 + 4 * n;
        exp_done = (frame[2+4*n] == x);
        exp_err  = !exp_done;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        got_addr.delete();
        got_data.delete();
    endtask

    // mode 0: back-to-back, 1: valid toggles every cycle, 2: random bubbles
    task automatic run_frame(input int mode);
        int i     = 0;
        int cyc   = 0;
        int limit = exp_len * 4 + 20;
        bit give;
        while (i < exp_len && cyc < limit) begin
            @(negedge clk);
            cyc++;
            case (mode)
                0:       give = 1'b1;
                1:       give = cyc[0];
                default: give = ($urandom % 3) != 0;
            endcase
            in_valid = give;
            in_data  = give ? frame[i] : 8'($urandom);
            if (give && in_ready) i++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bytes_accepted", 32'(i), 32'(exp_len));
        repeat (3) @(negedge clk);
    endtask

    task automatic compare_results(input string tag);
        check({tag, "_nwrites"}, 32'(got_data.size()), 32'(exp_data.size()));
        for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
            check({tag, "_addr"}, 32'(got_addr[k]), 32'(exp_addr[k]));
            check({tag, "_data"}, got_data[k], exp_data[k]);
        end
        check({tag, "_done"},      32'(done),      32'(exp_done));
        check({tag, "_error"},     32'(error),     32'(exp_err));
        check({tag, "_core_hold"}, 32'(core_hold), 32'(!exp_done));
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        check("in_ready_stream", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},   32'(in_ready),   32'd0);
        check({tag, "_imem_we"},    32'(imem_we),    32'd0);
        check({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
        check({tag, "_imem_wdata"}, imem_wdata,      32'd0);
        check({tag, "_core_hold"},  32'(core_hold),  32'd1);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_error"},      32'(error),      32'd0);
    endtask

    typedef struct packed {
        logic [7:0]  n;
        logic [95:0] bytes;
        logic [1:0]  mode;
        logic        done;
        logic        err;
        logic [7:0]  nw;
        logic [31:0] w0;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{n: 8'd11, bytes: 96'h00_B2_00_20_05_93_00_10_05_13_00_02,
                    mode: 2'd0, done: 1'b1, err: 1'b0, nw: 8'd2, w0: 32'h00100513};
        vecs[1] = '{n: 8'd11, bytes: 96'h00_00_00_20_05_93_00_10_05_13_00_02,
                    mode: 2'd0, done: 1'b0, err: 1'b1, nw: 8'd2, w0: 32'h00100513};
        vecs[2] = '{n: 8'd2,  bytes: 96'h0401,
                    mode: 2'd0, done: 1'b0, err: 1'b1, nw: 8'd0, w0: 32'h0};
        vecs[3] = '{n: 8'd3,  bytes: 96'h000000,
                    mode: 2'd0, done: 1'b1, err: 1'b0, nw: 8'd0, w0: 32'h0};
        vecs[4] = '{n: 8'd7,  bytes: 96'h07_00_10_05_13_00_01,
                    mode: 2'd1, done: 1'b1, err: 1'b0, nw: 8'd1, w0: 32'h00100513};
        vecs[5] = '{n: 8'd11, bytes: 96'h00_B2_00_20_05_93_00_10_05_13_00_02,
                    mode: 2'd2, done: 1'b1, err: 1'b0, nw: 8'd2, w0: 32'h00100513};

        // Reset state and in_ready rising one cycle after release.
        @(negedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("in_ready_pre_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("in_ready_post_release", 32'(in_ready), 32'd1);

        // Table-driven frames.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            frame.delete();
            for (int k = 0; k < int'(vecs[v].n); k++) frame.push_back(vecs[v].bytes[8*k +: 8]);
            model();
            run_frame(int'(vecs[v].mode));
            compare_results($sformatf("vec%0d", v));
            check($sformatf("vec%0d_tbl_done", v),  32'(done),  32'(vecs[v].done));
            check($sformatf("vec%0d_tbl_error", v), 32'(error), 32'(vecs[v].err));
            check($sformatf("vec%0d_tbl_nw", v),    32'(got_data.size()), 32'(vecs[v].nw));
            if (vecs[v].nw != 8'd0 && got_data.size() > 0)
                check($sformatf("vec%0d_tbl_w0", v), got_data[0], vecs[v].w0);
        end

        // Cycle-exact write strobe and release timing, one byte per cycle.
        do_reset();
        put(8'h02); put(8'h00); put(8'h13); put(8'h05); put(8'h10);
        check("seqA_we_early", 32'(imem_we), 32'd0);
        put(8'h00);
        check("seqA_we0", 32'(imem_we), 32'd1);
        check("seqA_addr0", 32'(imem_addr), 32'd0);
        check("seqA_data0", imem_wdata, 32'h00100513);
        put(8'h93);
        check("seqA_we_pulse", 32'(imem_we), 32'd0);
        put(8'h05); put(8'h20); put(8'h00);
        check("seqA_we1", 32'(imem_we), 32'd1);
        check("seqA_addr1", 32'(imem_addr), 32'd1);
        check("seqA_data1", imem_wdata, 32'h00200593);
        check("seqA_done_early", 32'(done), 32'd0);
        put(8'hB2);
        check("seqA_done", 32'(done), 32'd1);
        check("seqA_core_hold", 32'(core_hold), 32'd0);
        check("seqA_in_ready", 32'(in_ready), 32'd0);
        check("seqA_error", 32'(error), 32'd0);
        check("seqA_we_after", 32'(imem_we), 32'd0);

        // Oversize length: error the cycle after LEN_HI, never a write.
        do_reset();
        put(8'h01);
        put(8'h04);
        check("seqB_error", 32'(error), 32'd1);
        check("seqB_in_ready", 32'(in_ready), 32'd0);
        check("seqB_core_hold", 32'(core_hold), 32'd1);
        check("seqB_done", 32'(done), 32'd0);
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        check("seqB_nwrites", 32'(got_data.size()), 32'd0);

        // Reset mid-frame, then a clean load.
        do_reset();
        put(8'h01); put(8'h00); put(8'h13); put(8'h05); put(8'h10);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_values("seqC_midreset");
        in_valid = 1'b0;
        do_reset();
        frame.delete();
        frame = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01 ^ 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD};
        model();
        run_frame(0);
        compare_results("seqC");
        if (got_data.size() > 0) check("seqC_word", got_data[0], 32'hDDCCBBAA);

        // Random frames against the reference model.
        for (int t = 0; t < 40; t++) begin
            int         n;
            logic [7:0] x;
            do_reset();
            frame.delete();
            if (t == 0)                      n = 1 << AW;
            else if ($urandom_range(0, 9) == 0) n = $urandom_range((1 << AW) + 1, 65535);
            else                             n = $urandom_range(0, 6);
            frame.push_back(8'(n));
            frame.push_back(8'(n >> 8));
            if (n <= (1 << AW)) begin
                x = frame[0] ^ frame[1];
                for (int k = 0; k < 4 * n; k++) begin
                    frame.push_back(8'($urandom));
                    x ^= frame[frame.size() - 1];
                end
                if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
                frame.push_back(x);
            end
            model();
            run_frame((t == 0) ? 0 : $urandom_range(0, 2));
            compare_results($sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
